// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM ramp controller: FSM state encoding and
// default widths for the compare and period-divider datapaths.
package pwm_pkg;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_RAMP      = 2'd1,
      ST_RUN       = 2'd2,
      ST_RAMP_DOWN = 2'd3
   } pwm_state_t;

   localparam int PWM_WIDTH  = 16;
   localparam int PWM_TICK_W = 8;

endpackage

// File: rtl/pwm_ramp_step.sv
// One channel's saturating compare stepper: moves the compare value toward the
// target by at most one step without overshooting, plus an at-target flag.
module pwm_ramp_step
   import pwm_pkg::*;
#(
   parameter int WIDTH = PWM_WIDTH
) (
   input  logic [WIDTH-1:0] i_cmp,
   input  logic [WIDTH-1:0] i_tgt,
   input  logic [WIDTH-1:0] i_step,
   output logic [WIDTH-1:0] o_nxt,
   output logic             o_at_tgt
);

   // One extra bit catches carry on the way up and borrow on the way down,
   // so the result clamps at the target instead of wrapping.
   function automatic logic [WIDTH-1:0] sat_step(input logic [WIDTH-1:0] cmp,
                                                 input logic [WIDTH-1:0] tgt,
                                                 input logic [WIDTH-1:0] step);
      logic [WIDTH:0] up;
      logic [WIDTH:0] dn;
      up = {1'b0, cmp} + {1'b0, step};
      dn = {1'b0, cmp} - {1'b0, step};
      if (step == '0)
         return tgt;
      else if (cmp < tgt)
         return (up >= {1'b0, tgt}) ? tgt : up[WIDTH-1:0];
      else if (cmp > tgt)
         return (dn[WIDTH] || (dn[WIDTH-1:0] <= tgt)) ? tgt : dn[WIDTH-1:0];
      else
         return cmp;
   endfunction

   assign o_nxt    = sat_step(i_cmp, i_tgt, i_step);
   assign o_at_tgt = (i_cmp == i_tgt);

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// PWM compare ramp controller: steps two compare-end values toward live targets
// (or toward 0 when stopping) once every tick_div PWM periods.
module pwm_ramp_ctrl
   import pwm_pkg::*;
#(
   parameter int WIDTH  = PWM_WIDTH,
   parameter int TICK_W = PWM_TICK_W
) (
   input  logic              clk_psc_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic              stop_i,
   input  logic              period_tick_i,
   input  logic [TICK_W-1:0] tick_div_i,
   input  logic [WIDTH-1:0]  step_i,
   input  logic [WIDTH-1:0]  target_ch1_i,
   input  logic [WIDTH-1:0]  target_ch2_i,
   output logic              cnt_en_o,
   output logic [WIDTH-1:0]  cmp_ch1_end_o,
   output logic [WIDTH-1:0]  cmp_ch2_end_o,
   output logic              busy_o,
   output logic              done_o,
   output logic [1:0]        state_o
);

   pwm_state_t        r_state;
   pwm_state_t        w_state_nxt;
   logic [TICK_W-1:0] r_div_cnt;
   logic [TICK_W:0]   w_div_inc;
   logic [TICK_W:0]   w_div_lim;
   logic              w_in_ramp;
   logic              w_state_chg;
   logic              w_step_fire;
   logic [WIDTH-1:0]  r_cmp1;
   logic [WIDTH-1:0]  r_cmp2;
   logic [WIDTH-1:0]  w_tgt1;
   logic [WIDTH-1:0]  w_tgt2;
   logic [WIDTH-1:0]  w_nxt1;
   logic [WIDTH-1:0]  w_nxt2;
   logic              w_at1;
   logic              w_at2;
   logic              w_both_at;
   logic              r_cnt_en;
   logic              r_busy;
   logic              r_done;

   assign w_in_ramp   = (r_state == ST_RAMP) || (r_state == ST_RAMP_DOWN);
   assign w_div_lim   = (tick_div_i == '0) ? {{TICK_W{1'b0}}, 1'b1} : {1'b0, tick_div_i};
   assign w_div_inc   = {1'b0, r_div_cnt} + {{TICK_W{1'b0}}, 1'b1};
   assign w_state_chg = (w_state_nxt != r_state);
   // A tick landing on a state-change edge is dropped rather than stepping in the new state.
   assign w_step_fire = w_in_ramp && period_tick_i && !w_state_chg && (w_div_inc >= w_div_lim);

   assign w_tgt1    = (r_state == ST_RAMP_DOWN) ? '0 : target_ch1_i;
   assign w_tgt2    = (r_state == ST_RAMP_DOWN) ? '0 : target_ch2_i;
   assign w_both_at = w_at1 && w_at2;

   pwm_ramp_step #(.WIDTH(WIDTH)) u_step_ch1 (
      .i_cmp    (r_cmp1),
      .i_tgt    (w_tgt1),
      .i_step   (step_i),
      .o_nxt    (w_nxt1),
      .o_at_tgt (w_at1)
   );

   pwm_ramp_step #(.WIDTH(WIDTH)) u_step_ch2 (
      .i_cmp    (r_cmp2),
      .i_tgt    (w_tgt2),
      .i_step   (step_i),
      .o_nxt    (w_nxt2),
      .o_at_tgt (w_at2)
   );

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:      if (start_i && !stop_i) w_state_nxt = ST_RAMP;
         ST_RAMP:      if (stop_i)             w_state_nxt = ST_RAMP_DOWN;
                       else if (w_both_at)     w_state_nxt = ST_RUN;
         ST_RUN:       if (stop_i)             w_state_nxt = ST_RAMP_DOWN;
                       else if (!w_both_at)    w_state_nxt = ST_RAMP;
         ST_RAMP_DOWN: if (start_i && !stop_i) w_state_nxt = ST_RAMP;
                       else if (w_both_at)     w_state_nxt = ST_IDLE;
         default:                              w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_psc_i) begin
      if (rst_i) begin
         r_state   <= ST_IDLE;
         r_div_cnt <= '0;
         r_cmp1    <= '0;
         r_cmp2    <= '0;
         r_cnt_en  <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_cnt_en <= (w_state_nxt != ST_IDLE);
         r_busy   <= (w_state_nxt == ST_RAMP) || (w_state_nxt == ST_RAMP_DOWN);
         r_done   <= ((r_state == ST_RAMP) && (w_state_nxt == ST_RUN)) ||
                     ((r_state == ST_RAMP_DOWN) && (w_state_nxt == ST_IDLE));
         if (w_state_chg || !w_in_ramp)
            r_div_cnt <= '0;
         else if (period_tick_i)
            r_div_cnt <= w_step_fire ? '0 : w_div_inc[TICK_W-1:0];
         if (w_step_fire) begin
            r_cmp1 <= w_nxt1;
            r_cmp2 <= w_nxt2;
         end
      end
   end

   assign cnt_en_o      = r_cnt_en;
   assign cmp_ch1_end_o = r_cmp1;
   assign cmp_ch2_end_o = r_cmp2;
   assign busy_o        = r_busy;
   assign done_o        = r_done;
   assign state_o       = r_state;

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Directed bench for pwm_ramp_ctrl: ramp up/down, jump, saturation,
// contention, retarget, resume from ramp-down and reset mid-ramp.
module tb_pwm_ramp_ctrl;

   localparam int WIDTH  = 16;
   localparam int TICK_W = 8;

   logic              clk_psc_i = 1'b0;
   logic              rst_i;
   logic              start_i;
   logic              stop_i;
   logic              period_tick_i;
   logic [TICK_W-1:0] tick_div_i;
   logic [WIDTH-1:0]  step_i;
   logic [WIDTH-1:0]  target_ch1_i;
   logic [WIDTH-1:0]  target_ch2_i;
   logic              cnt_en_o;
   logic [WIDTH-1:0]  cmp_ch1_end_o;
   logic [WIDTH-1:0]  cmp_ch2_end_o;
   logic              busy_o;
   logic              done_o;
   logic [1:0]        state_o;

   int checks   = 0;
   int failures = 0;

   pwm_ramp_ctrl #(.WIDTH(WIDTH), .TICK_W(TICK_W)) dut (
      .clk_psc_i     (clk_psc_i),
      .rst_i         (rst_i),
      .start_i       (start_i),
      .stop_i        (stop_i),
      .period_tick_i (period_tick_i),
      .tick_div_i    (tick_div_i),
      .step_i        (step_i),
      .target_ch1_i  (target_ch1_i),
      .target_ch2_i  (target_ch2_i),
      .cnt_en_o      (cnt_en_o),
      .cmp_ch1_end_o (cmp_ch1_end_o),
      .cmp_ch2_end_o (cmp_ch2_end_o),
      .busy_o        (busy_o),
      .done_o        (done_o),
      .state_o       (state_o)
   );

   always #5 clk_psc_i = ~clk_psc_i;

   task automatic cyc();
      @(posedge clk_psc_i);
      #1;
   endtask

   task automatic tick();
      period_tick_i = 1'b1;
      cyc();
      period_tick_i = 1'b0;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
         $error("%s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst_i = 1'b1; start_i = 1'b0; stop_i = 1'b0; period_tick_i = 1'b0;
      tick_div_i = '0; step_i = '0; target_ch1_i = '0; target_ch2_i = '0;
      cyc(); cyc();
      chk("rst_state", state_o, 0);
      chk("rst_cnt_en", cnt_en_o, 0);
      chk("rst_cmp1", cmp_ch1_end_o, 0);
      chk("rst_cmp2", cmp_ch2_end_o, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_done", done_o, 0);

      // Ramp up, two periods per step, start right after reset release
      tick_div_i = 8'd2; step_i = 16'd100; target_ch1_i = 16'd250; target_ch2_i = 16'd100;
      rst_i = 1'b0; start_i = 1'b1;
      cyc();
      start_i = 1'b0;
      chk("up_state", state_o, 1);
      chk("up_cnt_en", cnt_en_o, 1);
      chk("up_busy", busy_o, 1);
      tick();
      chk("up_t1_cmp1", cmp_ch1_end_o, 0);
      tick();
      chk("up_t2_cmp1", cmp_ch1_end_o, 100);
      chk("up_t2_cmp2", cmp_ch2_end_o, 100);
      tick(); tick();
      chk("up_t4_cmp1", cmp_ch1_end_o, 200);
      chk("up_t4_cmp2", cmp_ch2_end_o, 100);
      tick(); tick();
      chk("up_t6_cmp1", cmp_ch1_end_o, 250);
      chk("up_t6_state", state_o, 1);
      chk("up_t6_done", done_o, 0);
      cyc();
      chk("up_run_state", state_o, 2);
      chk("up_run_done", done_o, 1);
      cyc();
      chk("up_run_done_clr", done_o, 0);
      chk("up_run_busy", busy_o, 0);

      // Stop from RUN, one period per step
      tick_div_i = 8'd1; step_i = 16'd100;
      stop_i = 1'b1;
      cyc();
      stop_i = 1'b0;
      chk("dn_state", state_o, 3);
      chk("dn_busy", busy_o, 1);
      tick();
      chk("dn_t1_cmp1", cmp_ch1_end_o, 150);
      chk("dn_t1_cmp2", cmp_ch2_end_o, 0);
      tick();
      chk("dn_t2_cmp1", cmp_ch1_end_o, 50);
      tick();
      chk("dn_t3_cmp1", cmp_ch1_end_o, 0);
      cyc();
      chk("dn_idle_state", state_o, 0);
      chk("dn_idle_cnt_en", cnt_en_o, 0);
      chk("dn_idle_done", done_o, 1);
      cyc();
      chk("dn_idle_done_clr", done_o, 0);

      // Stop alone, and start with stop, are both ignored in IDLE
      stop_i = 1'b1;
      cyc();
      chk("idle_stop_state", state_o, 0);
      start_i = 1'b1;
      cyc();
      start_i = 1'b0; stop_i = 1'b0;
      chk("idle_both_state", state_o, 0);

      // Jump with step 0; divider 0 behaves as 1
      tick_div_i = 8'd0; step_i = 16'd0; target_ch1_i = 16'hFFFF; target_ch2_i = 16'h1234;
      start_i = 1'b1;
      cyc();
      start_i = 1'b0;
      tick();
      chk("jump_cmp1", cmp_ch1_end_o, 32'hFFFF);
      chk("jump_cmp2", cmp_ch2_end_o, 32'h1234);
      cyc();
      chk("jump_run", state_o, 2);

      // Saturation from 0x2000: up clamps at 0xFFF0, down clamps at 0x1000
      target_ch1_i = 16'h2000; target_ch2_i = 16'h2000;
      cyc();
      chk("sat_retarget", state_o, 1);
      tick();
      cyc();
      chk("sat_pre_cmp1", cmp_ch1_end_o, 32'h2000);
      chk("sat_pre_run", state_o, 2);
      step_i = 16'hF000; target_ch1_i = 16'hFFF0; target_ch2_i = 16'h1000;
      cyc();
      tick();
      chk("sat_cmp1", cmp_ch1_end_o, 32'hFFF0);
      chk("sat_cmp2", cmp_ch2_end_o, 32'h1000);
      cyc();
      chk("sat_run", state_o, 2);

      // Retarget in RUN from 250 down to 50
      step_i = 16'd0; target_ch1_i = 16'd250; target_ch2_i = 16'd100;
      cyc(); tick(); cyc();
      chk("rt_pre_run", state_o, 2);
      step_i = 16'd100; target_ch1_i = 16'd50;
      cyc();
      chk("rt_state", state_o, 1);
      tick();
      chk("rt_t1_cmp1", cmp_ch1_end_o, 150);
      tick();
      chk("rt_t2_cmp1", cmp_ch1_end_o, 50);
      chk("rt_t2_cmp2", cmp_ch2_end_o, 100);
      cyc();
      chk("rt_run", state_o, 2);
      chk("rt_done", done_o, 1);

      // Resume from ramp-down; tick on the transition edge gives no step
      step_i = 16'd30;
      stop_i = 1'b1;
      cyc();
      stop_i = 1'b0;
      tick();
      chk("res_dn_cmp1", cmp_ch1_end_o, 20);
      chk("res_dn_cmp2", cmp_ch2_end_o, 70);
      start_i = 1'b1; period_tick_i = 1'b1;
      cyc();
      start_i = 1'b0; period_tick_i = 1'b0;
      chk("res_state", state_o, 1);
      chk("res_hold_cmp1", cmp_ch1_end_o, 20);
      chk("res_hold_cmp2", cmp_ch2_end_o, 70);
      tick();
      chk("res_up_cmp1", cmp_ch1_end_o, 50);
      chk("res_up_cmp2", cmp_ch2_end_o, 100);
      cyc();
      chk("res_run", state_o, 2);

      // Start and stop together in RUN: stop wins
      start_i = 1'b1; stop_i = 1'b1;
      cyc();
      start_i = 1'b0; stop_i = 1'b0;
      chk("cont_state", state_o, 3);
      step_i = 16'd0;
      tick();
      cyc();
      chk("cont_idle", state_o, 0);
      chk("cont_cnt_en", cnt_en_o, 0);

      // Reset in the middle of a ramp
      tick_div_i = 8'd1; step_i = 16'd10; target_ch1_i = 16'd250; target_ch2_i = 16'd100;
      start_i = 1'b1;
      cyc();
      start_i = 1'b0;
      tick(); tick();
      chk("mr_pre_cmp1", cmp_ch1_end_o, 20);
      rst_i = 1'b1;
      cyc();
      rst_i = 1'b0;
      chk("mr_state", state_o, 0);
      chk("mr_cmp1", cmp_ch1_end_o, 0);
      chk("mr_cmp2", cmp_ch2_end_o, 0);
      chk("mr_cnt_en", cnt_en_o, 0);
      chk("mr_busy", busy_o, 0);
      chk("mr_done", done_o, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pwm_ramp_ctrl.md
PWM_RAMP_CTRL -- requirements
Module: pwm_ramp_ctrl

Interface
REQ-001 Parameters, one per line:
- WIDTH, 16, counter/compare width
- TICK_W, 8, width of the period-divider field
REQ-002 Ports, one per line:
- clk_psc_i  in  1  clock (the PWM core clock)
- rst_i  in  1  reset; one clock; reset is synchronous and active-high
- start_i  in  1  single-cycle pulse; begin/resume ramp toward targets
- stop_i  in  1  single-cycle pulse; ramp both channels down to 0, then disable counter
- period_tick_i  in  1  one-cycle pulse per PWM period (counter overflow)
- tick_div_i  in  TICK_W  PWM periods per ramp step; 0 treated as 1
- step_i  in  WIDTH  compare increment/decrement per step; 0 means jump to target
- target_ch1_i  in  WIDTH  final compare-end value, channel 1
- target_ch2_i  in  WIDTH  final compare-end value, channel 2
- cnt_en_o  out  1  counter enable to the PWM core
- cmp_ch1_end_o  out  WIDTH  current compare-end value, channel 1
- cmp_ch2_end_o  out  WIDTH  current compare-end value, channel 2
- busy_o  out  1  high in RAMP or RAMP_DOWN
- done_o  out  1  one-cycle pulse on entering RUN or IDLE from a ramp
- state_o  out  2  current FSM state encoding

Function
REQ-003 FSM states: IDLE, RAMP, RUN, RAMP_DOWN.
REQ-004 IDLE: cnt_en_o=0, both compare outputs 0; start_i -> RAMP next cycle, cnt_en_o=1 from that cycle.
REQ-005 RAMP: effective target = target_chX_i, sampled live each step.
REQ-006 RAMP_DOWN: effective target = 0 for both channels.
REQ-007 Divider counter counts period_tick_i pulses in RAMP/RAMP_DOWN only; cleared on every state change.
REQ-008 A step fires on the period_tick_i pulse that makes the count equal max(tick_div_i,1); the count then clears.
REQ-009 Step per channel: if cmp<target, cmp=min(cmp+step, target); if cmp>target, cmp=max(cmp-step, target); else unchanged.
REQ-010 Step arithmetic uses WIDTH+1 bits; no wrap, saturate at target.
REQ-011 step_i=0 makes a step set cmp=target directly.
REQ-012 Compare outputs update only on step cycles, so updates coincide with period boundaries.
REQ-013 RAMP -> RUN in the cycle after both channels equal their targets; done_o pulses in the RUN entry cycle.
REQ-014 RUN holds outputs, cnt_en_o=1.
REQ-015 In RUN, any target_chX_i differing from cmp_chX_end_o -> RAMP next cycle (retarget without start_i).
REQ-016 RUN: start_i has no effect.
REQ-017 RAMP_DOWN -> IDLE in the cycle after both compare values are 0; cnt_en_o drops in the IDLE entry cycle; done_o pulses.
REQ-018 stop_i in RAMP or RUN -> RAMP_DOWN; stop_i in IDLE is ignored.
REQ-019 start_i in RAMP_DOWN -> RAMP, keeping current compare values.
REQ-020 start_i and stop_i in the same cycle: stop_i wins.
REQ-021 period_tick_i coinciding with a state transition does not produce a step in the new state.
REQ-022 busy_o and state_o are registered and consistent with the FSM state in the same cycle.

Reset
REQ-023 rst_i high at a clock edge forces IDLE, divider=0, both compare outputs=0, cnt_en_o=0, done_o=0, busy_o=0, including mid-ramp.
REQ-024 The first start_i is accepted on the first edge after rst_i deasserts.

Structure
REQ-025 Shared package pwm_pkg holds the FSM state encoding: IDLE=0, RAMP=1, RUN=2, RAMP_DOWN=3.
REQ-026 Shared package pwm_pkg holds default WIDTH and TICK_W constants.
REQ-027 One sub-module, pwm_ramp_step, implements one channel's saturating stepper (REQ-009..011) plus an at-target flag.
REQ-028 pwm_ramp_step is instantiated twice; FSM and divider live in pwm_ramp_ctrl.

Verification
REQ-029 Ramp up: tick_div=2, step=100, targets 250/100, start -> ch1 100,200,250 and ch2 100 on every 2nd tick; RUN after ch1=250; one done pulse.
REQ-030 Stop: in RUN with ch1=250/ch2=100, step=100, tick_div=1, stop -> ch1 150,50,0 and ch2 0; IDLE; cnt_en_o=0; done pulse.
REQ-031 Jump: step=0, target 0xFFFF, start -> 0xFFFF on first tick; no wrap.
REQ-032 Saturation: step=0xF000, target 0xFFF0 from 0x2000 -> 0xFFF0, not overflowed.
REQ-033 Contention: start and stop in the same cycle while in RUN -> RAMP_DOWN.
REQ-034 Retarget: target lowered from 250 to 50 in RUN -> RAMP, then down-steps to 50.
REQ-035 Reset mid-ramp: rst_i during RAMP -> all outputs 0 next cycle; state_o=IDLE.
